// File: rtl/peripheral_gpio_wb_master.sv
// Wishbone classic initiator for the GPIO register port.
// One command in flight; ack/err/timeout end it; sticky irq flag.
module peripheral_gpio_wb_master #(
  parameter int WB_DATA_WIDTH  = 32,
  parameter int WB_ADDR_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic                       cmd_we_i,
  input  logic [WB_ADDR_WIDTH-1:0]   cmd_adr_i,
  input  logic [WB_DATA_WIDTH-1:0]   cmd_dat_i,
  input  logic [WB_DATA_WIDTH/8-1:0] cmd_sel_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [WB_DATA_WIDTH-1:0]   rsp_dat_o,
  output logic                       rsp_err_o,
  output logic                       rsp_timeout_o,
  output logic                       wb_cyc_o,
  output logic                       wb_stb_o,
  output logic                       wb_we_o,
  output logic [WB_ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [WB_DATA_WIDTH-1:0]   wb_dat_o,
  output logic [WB_DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [WB_DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                       wb_ack_i,
  input  logic                       wb_err_i,
  input  logic                       wb_inta_i,
  output logic                       irq_pending_o,
  input  logic                       irq_clear_i
);

  localparam int SW = WB_DATA_WIDTH / 8;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam int CW =
    (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic                     we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [SW-1:0]            sel_q, sel_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [WB_DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic                     rerr_q, rerr_d;
  logic                     rto_q, rto_d;
  logic [1:0]               sync_q;
  logic                     sync_last_q;
  logic                     irq_q, irq_d;

  logic term_err, term_ack, term_to, done;

  // err outranks ack; timeout only when the slave is silent
  assign term_err = wb_err_i;
  assign term_ack = !wb_err_i && wb_ack_i;
  assign term_to  = TO_EN && !wb_err_i && !wb_ack_i
                    && (cnt_q == CNT_LAST);
  assign done     = term_err || term_ack || term_to;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid_i) state_d = BUS;
      BUS:     if (done)        state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = (state_q == IDLE);
    rsp_valid_o = (state_q == RESP);
    wb_cyc_o    = (state_q == BUS);
    wb_stb_o    = (state_q == BUS);
  end

  always_comb begin
    we_d   = we_q;
    adr_d  = adr_q;
    wdat_d = wdat_q;
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    rdat_d = rdat_q;
    rerr_d = rerr_q;
    rto_d  = rto_q;
    if (state_q == IDLE && cmd_valid_i) begin
      we_d   = cmd_we_i;
      adr_d  = cmd_adr_i;
      wdat_d = cmd_dat_i;
      sel_d  = cmd_sel_i;
      cnt_d  = '0;
    end
    if (state_q == BUS) begin
      if (done) begin
        rdat_d = (term_ack && !we_q) ? wb_dat_i : '0;
        rerr_d = term_err || term_to;
        rto_d  = term_to;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign irq_d = (sync_q[1] && !sync_last_q)
                 || (irq_q && !irq_clear_i);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdat_q      <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      rdat_q      <= '0;
      rerr_q      <= 1'b0;
      rto_q       <= 1'b0;
      sync_q      <= '0;
      sync_last_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      we_q        <= we_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      rdat_q      <= rdat_d;
      rerr_q      <= rerr_d;
      rto_q       <= rto_d;
      sync_q      <= {sync_q[0], wb_inta_i};
      sync_last_q <= sync_q[1];
      irq_q       <= irq_d;
    end
  end

  assign wb_we_o       = we_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = wdat_q;
  assign wb_sel_o      = sel_q;
  assign rsp_dat_o     = rdat_q;
  assign rsp_err_o     = rerr_q;
  assign rsp_timeout_o = rto_q;
  assign irq_pending_o = irq_q;

endmodule

// File: tb/tb_peripheral_gpio_wb_master.sv
// Bench for peripheral_gpio_wb_master: vector table, random
// commands against a termination model, reset/irq/no-timeout cases.
module tb_peripheral_gpio_wb_master;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [7:0]  cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_to;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we;
  logic [7:0]  adr;
  logic [31:0] wdat, rdat;
  logic [3:0]  sel;
  logic        ack, err, inta, irqp, irqc;

  logic        cmd_valid2, cmd_ready2;
  logic        rsp_valid2, rsp_err2, rsp_to2;
  logic [31:0] rsp_dat2, wdat2;
  logic        cyc2, stb2, we2, irqp2;
  logic [7:0]  adr2;
  logic [3:0]  sel2;

  peripheral_gpio_wb_master #(
    .WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr),
    .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .rsp_timeout_o(rsp_to),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we),
    .wb_adr_o(adr), .wb_dat_o(wdat), .wb_sel_o(sel),
    .wb_dat_i(rdat), .wb_ack_i(ack), .wb_err_i(err),
    .wb_inta_i(inta), .irq_pending_o(irqp),
    .irq_clear_i(irqc)
  );

  peripheral_gpio_wb_master #(
    .WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(8), .TIMEOUT_CYCLES(0)
  ) dut_nto (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid2), .cmd_ready_o(cmd_ready2),
    .cmd_we_i(1'b0), .cmd_adr_i(8'h14),
    .cmd_dat_i(32'h0), .cmd_sel_i(4'hF),
    .rsp_valid_o(rsp_valid2), .rsp_ready_i(1'b1),
    .rsp_dat_o(rsp_dat2), .rsp_err_o(rsp_err2),
    .rsp_timeout_o(rsp_to2),
    .wb_cyc_o(cyc2), .wb_stb_o(stb2), .wb_we_o(we2),
    .wb_adr_o(adr2), .wb_dat_o(wdat2), .wb_sel_o(sel2),
    .wb_dat_i(32'h0), .wb_ack_i(1'b0), .wb_err_i(1'b0),
    .wb_inta_i(1'b0), .irq_pending_o(irqp2),
    .irq_clear_i(1'b0)
  );

  // term: 0 ack, 1 err, 2 ack+err, 3 silent slave
  typedef struct {
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          term;
    int          waits;
    logic [31:0] rd;
    int          exp_cyc;
    logic        exp_err;
    logic        exp_to;
    logic [31:0] exp_dat;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic we_, input logic [7:0] a, input logic [31:0] d,
    input logic [3:0] s, input int t, input int w,
    input logic [31:0] r, input int ec, input logic ee,
    input logic et, input logic [31:0] ed);
    vec_t v;
    v.we = we_; v.adr = a; v.dat = d; v.sel = s;
    v.term = t; v.waits = w; v.rd = r;
    v.exp_cyc = ec; v.exp_err = ee; v.exp_to = et;
    v.exp_dat = ed;
    return v;
  endfunction

  // Slave answers in bus cycle waits+1 unless the timeout hits first
  function automatic vec_t model(input vec_t v);
    vec_t o;
    bit fin;
    o = v;
    fin = (v.term != 3) && (v.waits + 1 <= TO);
    o.exp_cyc = fin ? v.waits + 1 : TO;
    o.exp_to  = !fin;
    o.exp_err = !fin || (v.term != 0);
    o.exp_dat = (fin && v.term == 0 && !v.we) ? v.rd : 32'h0;
    return o;
  endfunction

  task automatic run_cmd(input vec_t v, input int hold);
    int n;
    bit fire;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_we = v.we; cmd_adr = v.adr;
    cmd_dat = v.dat; cmd_sel = v.sel;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    cmd_we = ~v.we; cmd_adr = ~v.adr;
    cmd_dat = ~v.dat; cmd_sel = ~v.sel;
    n = 0;
    while (cyc === 1'b1 && n < 50) begin
      n++;
      chk("bus_stb", 64'(stb), 64'd1);
      chk("bus_we", 64'(we), 64'(v.we));
      chk("bus_adr", 64'(adr), 64'(v.adr));
      chk("bus_dat", 64'(wdat), 64'(v.dat));
      chk("bus_sel", 64'(sel), 64'(v.sel));
      chk("bus_rsp_valid", 64'(rsp_valid), 64'd0);
      fire = (v.term != 3) && (n == v.waits + 1);
      ack  = fire && (v.term == 0 || v.term == 2);
      err  = fire && (v.term == 1 || v.term == 2);
      rdat = fire ? v.rd : $urandom;
      @(posedge clk); @(negedge clk);
      ack = 1'b0; err = 1'b0;
    end
    chk("cyc_cycles", 64'(n), 64'(v.exp_cyc));
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_err", 64'(rsp_err), 64'(v.exp_err));
      chk("rsp_timeout", 64'(rsp_to), 64'(v.exp_to));
      chk("rsp_dat", 64'(rsp_dat), 64'(v.exp_dat));
      chk("resp_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("resp_cyc", 64'(cyc), 64'd0);
      if (i == hold) rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk("after_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("after_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("after_cyc", 64'(cyc), 64'd0);
  endtask

  vec_t tbl[8];

  initial begin
    vec_t v;
    int hi, rv;
    tbl[0] = mk(1, 8'h04, 32'hA5A5_0000, 4'hF, 0, 0,
                32'hFFFF_FFFF, 1, 0, 0, 32'h0);
    tbl[1] = mk(0, 8'h00, 32'h0, 4'hF, 0, 3,
                32'h1234_5678, 4, 0, 0, 32'h1234_5678);
    tbl[2] = mk(0, 8'h08, 32'h1, 4'hF, 2, 1,
                32'hDEAD_BEEF, 2, 1, 0, 32'h0);
    tbl[3] = mk(1, 8'h0C, 32'h5555_AAAA, 4'h3, 1, 0,
                32'h0BAD_F00D, 1, 1, 0, 32'h0);
    tbl[4] = mk(0, 8'h10, 32'h0, 4'hF, 3, 0,
                32'h1111_2222, 4, 1, 1, 32'h0);
    tbl[5] = mk(1, 8'h18, 32'h7, 4'h1, 3, 0,
                32'h0, 4, 1, 1, 32'h0);
    tbl[6] = mk(0, 8'h1C, 32'h0, 4'h3, 0, 2,
                32'hCAFE_F00D, 3, 0, 0, 32'hCAFE_F00D);
    tbl[7] = mk(0, 8'h20, 32'h0, 4'hF, 0, 4,
                32'h9999_9999, 4, 1, 1, 32'h0);

    rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_adr = 0;
    cmd_dat = 0; cmd_sel = 0; rsp_ready = 0; rdat = 0;
    ack = 0; err = 0; inta = 0; irqc = 0; cmd_valid2 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_fields", {rsp_dat, 30'h0, rsp_err, rsp_to}, 64'd0);
    chk("rst_wb_ctl", {61'h0, cyc, stb, we}, 64'd0);
    chk("rst_wb_adr", 64'(adr), 64'd0);
    chk("rst_wb_dat", 64'(wdat), 64'd0);
    chk("rst_wb_sel", 64'(sel), 64'd0);
    chk("rst_irq", 64'(irqp), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_cmd(tbl[i], (i == 1) ? 10 : 0);

    for (int i = 0; i < 40; i++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.adr   = 8'($urandom);
      v.dat   = $urandom;
      v.sel   = 4'($urandom);
      v.term  = $urandom_range(0, 3);
      v.waits = $urandom_range(0, 5);
      v.rd    = $urandom;
      run_cmd(model(v), $urandom_range(0, 3));
    end

    cmd_valid = 1'b1; cmd_we = 0; cmd_adr = 8'h24;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midbus_cyc", 64'(cyc), 64'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("abort_cyc", {62'h0, cyc, stb}, 64'd0);
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    rv = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid || cyc) rv++;
      @(posedge clk); @(negedge clk);
    end
    chk("abort_no_rsp", 64'(rv), 64'd0);

    inta = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("irq_2edges", 64'(irqp), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("irq_3edges", 64'(irqp), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("irq_sticky", 64'(irqp), 64'd1);
    irqc = 1'b1;
    @(posedge clk); @(negedge clk);
    irqc = 1'b0;
    chk("irq_cleared", 64'(irqp), 64'd0);
    inta = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("irq_fall_no_set", 64'(irqp), 64'd0);
    inta = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    irqc = 1'b1;
    @(posedge clk); @(negedge clk);
    irqc = 1'b0;
    chk("irq_set_wins", 64'(irqp), 64'd1);

    cmd_valid2 = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid2 = 1'b0;
    hi = 0; rv = 0;
    repeat (1000) begin
      if (cyc2) hi++;
      if (rsp_valid2) rv++;
      @(posedge clk); @(negedge clk);
    end
    chk("nto_cyc_held", 64'(hi), 64'd1000);
    chk("nto_no_rsp", 64'(rv), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/peripheral_gpio_wb_master.md
# peripheral_gpio_wb_master

Single-outstanding Wishbone classic-cycle initiator that drives the register port of the GPIO peripheral from a simple valid/ready command stream. A command is one register read or write. The block runs the bus cycle, terminates it on ack, on err, or on a programmable timeout, and returns one response per command. It sits between a host-side sequencer (CPU bridge or test driver) and the GPIO slave's `wb_*` inputs. It also synchronises that slave's interrupt line into a sticky, clearable flag.

## Interface
- `WB_DATA_WIDTH`, 32: data bus width; `wb_sel_o` is `WB_DATA_WIDTH/8` bits.
- `WB_ADDR_WIDTH`, 8: address bus width.
- `TIMEOUT_CYCLES`, 255: maximum number of bus cycles to wait for ack or err; 0 disables the timeout.

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: synchronous reset, active-high.
- `cmd_valid_i` in 1: a command is presented.
- `cmd_ready_o` out 1: the block accepts the command in this cycle.
- `cmd_we_i` in 1: 1 = write, 0 = read.
- `cmd_adr_i` in `WB_ADDR_WIDTH`: register address.
- `cmd_dat_i` in `WB_DATA_WIDTH`: write data.
- `cmd_sel_i` in `WB_DATA_WIDTH/8`: byte selects.
- `rsp_valid_o` out 1: a response is available.
- `rsp_ready_i` in 1: the consumer takes the response.
- `rsp_dat_o` out `WB_DATA_WIDTH`: read data; 0 for writes and for failed cycles.
- `rsp_err_o` out 1: the cycle ended with err or timeout.
- `rsp_timeout_o` out 1: the cycle ended by timeout.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1: Wishbone cycle, strobe and write-enable.
- `wb_adr_o` out `WB_ADDR_WIDTH`, `wb_dat_o` out `WB_DATA_WIDTH`, `wb_sel_o` out `WB_DATA_WIDTH/8`: Wishbone address, write data and byte selects.
- `wb_dat_i` in `WB_DATA_WIDTH`, `wb_ack_i` in 1, `wb_err_i` in 1: slave read data and terminations.
- `wb_inta_i` in 1: interrupt from the slave.
- `irq_pending_o` out 1: sticky interrupt flag.
- `irq_clear_i` in 1: clears `irq_pending_o`.

## Operation
- **FSM states:** IDLE, BUS, RESP. Reset state is IDLE.
- **IDLE:**
  - `cmd_ready_o`=1.
  - On `cmd_valid_i`: register `we`/`adr`/`dat`/`sel` onto the `wb_*` outputs, clear the timeout counter, and go to BUS.
- **BUS:**
  - `wb_cyc_o` = `wb_stb_o` = 1.
  - `wb_adr_o`, `wb_dat_o`, `wb_sel_o` and `wb_we_o` are held stable for the whole cycle.
  - Termination is sampled on each rising edge:
    - `wb_err_i`=1: `rsp_err_o`=1, `rsp_dat_o`=0. err wins over a simultaneous ack.
    - else `wb_ack_i`=1: `rsp_err_o`=0; `rsp_dat_o` = `wb_dat_i` if read, else 0.
    - else, if `TIMEOUT_CYCLES`≠0 and counter = `TIMEOUT_CYCLES`-1: `rsp_err_o`=1, `rsp_timeout_o`=1, `rsp_dat_o`=0.
    - else the counter increments.
  - On any termination: go to RESP, and deassert `cyc`/`stb` in the same edge.
  - The counter width is `$clog2(TIMEOUT_CYCLES+1)`, minimum 1. It saturates and never wraps.
- **RESP:**
  - `rsp_valid_o`=1 and the response fields are held stable.
  - `cmd_ready_o`=0.
  - On `rsp_ready_i`: go to IDLE.
- `wb_dat_o` is driven with the command data for reads too. Slaves ignore it when `we`=0.
- **Interrupt path:**
  - `wb_inta_i` passes through a 2-flop synchroniser.
  - A rising edge of the synchronised signal sets `irq_pending_o`.
  - `irq_clear_i` clears it. If set and clear coincide, set wins.
- **Reset:** a synchronous `wb_rst_i` in any state returns to IDLE at the next edge. `cyc`/`stb` drop at that edge, even mid-cycle, and no response is produced for the aborted command.

## Timing
- **Reset values:**
  - `cmd_ready_o`=1.
  - All other outputs 0: `rsp_*`, `wb_*`, `irq_pending_o`.
  - Synchroniser flops 0.
- **Command accept:** at edge E0 when `cmd_valid_i` && `cmd_ready_o`. Then `wb_cyc_o`/`wb_stb_o` are high from E0 to the terminating edge.
- **Minimum latency:** a slave acking in the first bus cycle gives a termination sample at E1, and `rsp_valid_o` is high after E1. That is 2 cycles from command to response, and `cyc` stays high for exactly 1 cycle.
- **Back-to-back commands:** `rsp_ready_i` sampled at edge R; `cmd_ready_o` is high after R. The earliest next `cyc` is after R+1, so there is at least one idle bus cycle between Wishbone cycles.
- **Timeout:** with no ack and no err, `cyc` stays high for exactly `TIMEOUT_CYCLES` cycles.
- **Interrupt:** `irq_pending_o` rises 3 edges after `wb_inta_i` rises.

## Test plan
- **Write, 1-cycle-ack slave:** cmd write adr=0x04, dat=0xA5A5_0000, sel=0xF → `cyc`/`stb`/`we` high 1 cycle with `wb_adr_o`=0x04 and `wb_dat_o`=0xA5A5_0000; then `rsp_valid_o`=1, `rsp_err_o`=0, `rsp_dat_o`=0.
- **Read, 3 wait states:** cmd read adr=0x00; slave drives `wb_dat_i`=0x1234_5678 with ack in the 4th bus cycle → `cyc` high 4 cycles, `rsp_dat_o`=0x1234_5678, `rsp_err_o`=0.
- **Err wins:** `wb_ack_i` and `wb_err_i` asserted together → `rsp_err_o`=1, `rsp_timeout_o`=0, `rsp_dat_o`=0.
- **Timeout:** `TIMEOUT_CYCLES`=4, slave silent → `cyc` high exactly 4 cycles, then `rsp_err_o`=1 and `rsp_timeout_o`=1. Repeat with `TIMEOUT_CYCLES`=0 for 1000 cycles → `cyc` remains high and no response appears.
- **Backpressure and reset:** hold `rsp_ready_i`=0 for 10 cycles → response fields stable and `cmd_ready_o`=0 throughout. Then assert `wb_rst_i` during BUS → `cyc`=0 after the next edge, `rsp_valid_o` never asserted, `cmd_ready_o`=1.
- **Interrupt:** `wb_inta_i` 0→1 → `irq_pending_o`=1 after 3 edges. Pulse `irq_clear_i` → 0 next edge. Clear coincident with a new rising edge → stays 1.
